// File: rtl/cpu_bus_map.sv
// cpu_bus_map: CPU-side NES bus decoder.
// Decodes the 16-bit CPU bus into PrgROM, mirrored work RAM, cartridge SRAM,
// mirrored PPU registers, two joypad shift registers and the $4014 OAM DMA
// engine, which stalls the CPU through rdy.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   addr, ren, wen, wdata, rdata  CPU bus (rdata is combinational)
//   rdy                           0 while DMA owns the bus
//   ppu_ren/wen/addr/wdata/rdata  PPU register port
//   rom_wen/waddr/wdata           ROM preload, honoured only during reset
//   joy1_btn, joy2_btn            live pad buttons, bit0 = A
//   err                           single-cycle pulse on an illegal access
module cpu_bus_map #(
    parameter int unsigned ROM_AW   = 15,
    parameter int unsigned RAM_AW   = 11,
    parameter int unsigned SRAM_AW  = 13,
    parameter int unsigned DMA_LEN  = 256,
    parameter int unsigned JOY_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [15:0]         addr,
    input  logic                ren,
    input  logic                wen,
    input  logic [7:0]          wdata,
    output logic [7:0]          rdata,
    output logic                rdy,
    output logic                ppu_ren,
    output logic                ppu_wen,
    output logic [2:0]          ppu_addr,
    output logic [7:0]          ppu_wdata,
    input  logic [7:0]          ppu_rdata,
    input  logic                rom_wen,
    input  logic [ROM_AW-1:0]   rom_waddr,
    input  logic [7:0]          rom_wdata,
    input  logic [JOY_BITS-1:0] joy1_btn,
    input  logic [JOY_BITS-1:0] joy2_btn,
    output logic                err
);

    localparam int unsigned ROM_DEPTH  = 2 ** ROM_AW;
    localparam int unsigned RAM_DEPTH  = 2 ** RAM_AW;
    localparam int unsigned SRAM_DEPTH = 2 ** SRAM_AW;
    localparam logic [7:0]  LAST_IDX   = 8'(DMA_LEN - 1);
    // Bit shifted in at the top of a pad register so over-reads return 1.
    localparam logic [JOY_BITS-1:0] JOY_FILL = JOY_BITS'(1) << (JOY_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ALIGN,
        S_RD,
        S_WR
    } dma_state_t;

    logic [7:0] rom_mem  [ROM_DEPTH];
    logic [7:0] ram_mem  [RAM_DEPTH];
    logic [7:0] sram_mem [SRAM_DEPTH];

    dma_state_t          state;
    logic [7:0]          dma_page;
    logic [7:0]          dma_idx;
    logic [7:0]          dma_buf;
    logic                strobe;
    logic [JOY_BITS-1:0] sr1;
    logic [JOY_BITS-1:0] sr2;

    // Region decode on addr[15:13]
    logic is_rom, is_sram, is_ram, is_ppu, is_io;
    assign is_rom  = addr[15];
    assign is_sram = (addr[15:13] == 3'b011);
    assign is_ram  = (addr[15:13] == 3'b000);
    assign is_ppu  = (addr[15:13] == 3'b001);
    assign is_io   = (addr[15:13] == 3'b010);

    logic io_dma, io_joy1, io_joy2;
    assign io_dma  = (addr == 16'h4014);
    assign io_joy1 = (addr == 16'h4016);
    assign io_joy2 = (addr == 16'h4017);

    // CPU strobes qualified by reset and DMA ownership; a write beats a read
    logic cpu_rd, cpu_wr, cpu_both;
    assign rdy      = (state == S_IDLE);
    assign cpu_rd   = ren & ~wen & rdy & ~rst;
    assign cpu_wr   = wen & rdy & ~rst;
    assign cpu_both = ren & wen & rdy & ~rst;

    logic [15:0] dma_src;
    logic        src_bad;
    logic        dma_wr;
    assign dma_src = {dma_page, dma_idx};
    assign src_bad = (dma_src[15:13] == 3'b001) || (dma_src[15:13] == 3'b010);
    assign dma_wr  = ~rst & (state == S_WR);

    // Memory-backed read shared by the CPU port and the DMA source; 0 for PPU/IO
    function automatic logic [7:0] mem_read(input logic [15:0] a);
        logic [7:0] d;
        d = 8'h00;
        if (a[15]) begin
            d = rom_mem[a[ROM_AW-1:0]];
        end else if (a[14:13] == 2'b11) begin
            d = sram_mem[a[SRAM_AW-1:0]];
        end else if (a[14:13] == 2'b00) begin
            d = ram_mem[a[RAM_AW-1:0]];
        end
        return d;
    endfunction

    // Zero-latency CPU read data
    always_comb begin
        rdata = 8'h00;
        if (cpu_rd) begin
            if (is_ppu) begin
                rdata = ppu_rdata;
            end else if (is_io) begin
                if (io_joy1) begin
                    rdata = {7'b0, sr1[0]};
                end else if (io_joy2) begin
                    rdata = {7'b0, sr2[0]};
                end
            end else begin
                rdata = mem_read(addr);
            end
        end
    end

    // PPU port: DMA owns it in WR, otherwise it follows the CPU
    assign ppu_ren   = cpu_rd & is_ppu;
    assign ppu_wen   = (cpu_wr & is_ppu) | dma_wr;
    assign ppu_addr  = dma_wr ? 3'd4 : addr[2:0];
    assign ppu_wdata = dma_wr ? dma_buf : wdata;

    // Illegal: ROM write, unimplemented IO, read+write together, DMA from PPU/IO
    logic cpu_err, dma_err;
    assign cpu_err = (cpu_wr & (is_rom | (is_io & ~(io_dma | io_joy1 | io_joy2))))
                   | (cpu_rd & is_io & ~(io_joy1 | io_joy2))
                   | cpu_both;
    assign dma_err = ~rst & (state == S_RD) & src_bad;
    assign err     = cpu_err | dma_err;

    // ROM keeps its contents across reset; preload is only accepted during reset
    always_ff @(posedge clk) begin
        if (rst && rom_wen) begin
            rom_mem[rom_waddr] <= rom_wdata;
        end
    end

    // RAM/SRAM, joypads and the DMA engine
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            dma_page <= 8'h00;
            dma_idx  <= 8'h00;
            dma_buf  <= 8'h00;
            strobe   <= 1'b0;
            sr1      <= '0;
            sr2      <= '0;
            for (int unsigned i = 0; i < RAM_DEPTH; i++) begin
                ram_mem[i] <= 8'h00;
            end
            for (int unsigned i = 0; i < SRAM_DEPTH; i++) begin
                sram_mem[i] <= 8'h00;
            end
        end else begin
            if (cpu_wr && is_ram) begin
                ram_mem[addr[RAM_AW-1:0]] <= wdata;
            end
            if (cpu_wr && is_sram) begin
                sram_mem[addr[SRAM_AW-1:0]] <= wdata;
            end
            if (cpu_wr && io_joy1) begin
                strobe <= wdata[0];
            end

            // Strobe high reloads every cycle; each read with strobe low shifts
            if (strobe) begin
                sr1 <= joy1_btn;
                sr2 <= joy2_btn;
            end else begin
                if (cpu_rd && io_joy1) begin
                    sr1 <= (sr1 >> 1) | JOY_FILL;
                end
                if (cpu_rd && io_joy2) begin
                    sr2 <= (sr2 >> 1) | JOY_FILL;
                end
            end

            case (state)
                S_IDLE: begin
                    if (cpu_wr && io_dma) begin
                        dma_page <= wdata;
                        dma_idx  <= 8'h00;
                        state    <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    state <= S_RD;
                end
                S_RD: begin
                    dma_buf <= mem_read(dma_src);
                    state   <= S_WR;
                end
                S_WR: begin
                    dma_idx <= dma_idx + 8'd1;
                    state   <= (dma_idx == LAST_IDX) ? S_IDLE : S_RD;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_map.sv
// tb_cpu_bus_map: directed and randomized bench for cpu_bus_map against a
// behavioural bus model (address-range arithmetic over plain arrays).
// A second instance with DMA_LEN=4 shares all inputs to check the short stall.
module tb_cpu_bus_map;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic        ren, wen;
    logic [7:0]  wdata;
    logic [7:0]  ppu_rdata;
    logic        rom_wen;
    logic [14:0] rom_waddr;
    logic [7:0]  rom_wdata;
    logic [7:0]  joy1_btn, joy2_btn;

    logic [7:0]  rdata, ppu_wdata;
    logic        rdy, ppu_ren, ppu_wen, err;
    logic [2:0]  ppu_addr;

    logic [7:0]  rdata_4, ppu_wdata_4;
    logic        rdy_4, ppu_ren_4, ppu_wen_4, err_4;
    logic [2:0]  ppu_addr_4;

    always #5 clk = ~clk;

    cpu_bus_map u_dut (
        .clk(clk), .rst(rst), .addr(addr), .ren(ren), .wen(wen), .wdata(wdata),
        .rdata(rdata), .rdy(rdy), .ppu_ren(ppu_ren), .ppu_wen(ppu_wen),
        .ppu_addr(ppu_addr), .ppu_wdata(ppu_wdata), .ppu_rdata(ppu_rdata),
        .rom_wen(rom_wen), .rom_waddr(rom_waddr), .rom_wdata(rom_wdata),
        .joy1_btn(joy1_btn), .joy2_btn(joy2_btn), .err(err)
    );

    cpu_bus_map #(.DMA_LEN(4)) u_dut4 (
        .clk(clk), .rst(rst), .addr(addr), .ren(ren), .wen(wen), .wdata(wdata),
        .rdata(rdata_4), .rdy(rdy_4), .ppu_ren(ppu_ren_4), .ppu_wen(ppu_wen_4),
        .ppu_addr(ppu_addr_4), .ppu_wdata(ppu_wdata_4), .ppu_rdata(ppu_rdata),
        .rom_wen(rom_wen), .rom_waddr(rom_waddr), .rom_wdata(rom_wdata),
        .joy1_btn(joy1_btn), .joy2_btn(joy2_btn), .err(err_4)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] ram_m  [2048];
    logic [7:0] sram_m [8192];
    logic [7:0] rom_m  [int];
    int         rom_keys[$];
    logic [7:0] exp_data [256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_read(input logic [15:0] a);
        if (a >= 16'h8000) return rom_m[int'(a) - 32'h8000];
        if (a >= 16'h6000) return sram_m[int'(a) - 32'h6000];
        if (a <  16'h2000) return ram_m[int'(a) % 2048];
        return 8'h00;
    endfunction

    task automatic clear_model();
        foreach (ram_m[i])  ram_m[i]  = 8'h00;
        foreach (sram_m[i]) sram_m[i] = 8'h00;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        addr = a; wdata = d; wen = 1'b1; ren = 1'b0;
        cyc();
        wen = 1'b0;
        if (a < 16'h2000) ram_m[int'(a) % 2048] = d;
        else if (a >= 16'h6000 && a < 16'h8000) sram_m[int'(a) - 32'h6000] = d;
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] exp_d,
                      input logic exp_err);
        addr = a; ren = 1'b1; wen = 1'b0;
        #1;
        chk(tag, rdata, exp_d);
        chk({tag, "_err"}, err, exp_err);
        cyc();
        ren = 1'b0;
    endtask

    // Runs one DMA; optional reset abort at loop cycle abort_at; CPU pokes at 20/50
    task automatic run_dma(input logic [7:0] page, input int abort_at,
                           output int stall, output int nwr, output int nerr,
                           output int stall4, output int nwr4);
        stall = 0; nwr = 0; nerr = 0; stall4 = 0; nwr4 = 0;
        wr(16'h4014, page);
        for (int c = 0; c < 700; c++) begin
            ren   = (c == 20);
            wen   = (c == 50);
            addr  = (c == 20) ? 16'h0005 : 16'h0010;
            wdata = 8'hEE;
            rst   = (c == abort_at);
            #1;
            if (!rdy_4) stall4++;
            if (ppu_wen_4) begin
                if (nwr4 < 256) chk("dma4_data", ppu_wdata_4, exp_data[nwr4]);
                nwr4++;
            end
            if (rdy) break;
            stall++;
            if (c == 20) chk("dma_stall_rdata", rdata, 8'h00);
            if (c == abort_at) chk("abort_cycle_wen", ppu_wen, 1'b0);
            if (ppu_wen) begin
                chk("dma_addr", ppu_addr, 3'd4);
                if (nwr < 256) chk("dma_data", ppu_wdata, exp_data[nwr]);
                nwr++;
            end
            if (err) nerr++;
            cyc();
        end
        rst = 1'b0; ren = 1'b0; wen = 1'b0;
    endtask

    initial begin
        int st, nw, ne, st4, nw4;
        logic [7:0]  d, btn1, btn2;
        logic [15:0] a;
        int region, op, key;

        rst = 1'b1; addr = 16'h0000; ren = 1'b0; wen = 1'b0; wdata = 8'h00;
        ppu_rdata = 8'h00; rom_wen = 1'b0; rom_waddr = '0; rom_wdata = 8'h00;
        joy1_btn = 8'h00; joy2_btn = 8'h00;
        clear_model();

        // ROM preload during reset: page $80 fully, plus random addresses
        for (int i = 0; i < 256; i++) begin
            d = 8'($urandom);
            rom_wen = 1'b1; rom_waddr = 15'(i); rom_wdata = d;
            rom_m[i] = d; rom_keys.push_back(i);
            cyc();
        end
        for (int i = 0; i < 64; i++) begin
            key = int'($urandom_range(256, 32767));
            if (!rom_m.exists(key)) begin
                d = 8'($urandom);
                rom_wen = 1'b1; rom_waddr = 15'(key); rom_wdata = d;
                rom_m[key] = d; rom_keys.push_back(key);
                cyc();
            end
        end
        rom_wen = 1'b0;

        // Reset state with strobes active: everything held quiet
        addr = 16'h2002; ren = 1'b1;
        #1;
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_rdy", rdy, 1'b1);
        chk("rst_ppu_ren", ppu_ren, 1'b0);
        chk("rst_err", err, 1'b0);
        ren = 1'b0; wen = 1'b1;
        #1;
        chk("rst_ppu_wen", ppu_wen, 1'b0);
        cyc();
        wen = 1'b0;
        rst = 1'b0;
        cyc();

        // RAM cleared; ROM preload ignored outside reset
        rd("ram_cleared", 16'h0123, 8'h00, 1'b0);
        rom_wen = 1'b1; rom_waddr = 15'h0000; rom_wdata = ~rom_m[0];
        cyc();
        rom_wen = 1'b0;
        rd("rom_no_preload", 16'h8000, rom_m[0], 1'b0);

        // RAM mirroring
        wr(16'h0005, 8'hA5);
        rd("ram_mirror_0805", 16'h0805, 8'hA5, 1'b0);
        rd("ram_mirror_1805", 16'h1805, 8'hA5, 1'b0);

        // PPU read and ROM write protection
        ppu_rdata = 8'h3C; addr = 16'h3FFA; ren = 1'b1;
        #1;
        chk("ppu_ren", ppu_ren, 1'b1);
        chk("ppu_addr", ppu_addr, 3'd2);
        chk("ppu_rdata", rdata, 8'h3C);
        cyc();
        ren = 1'b0;
        addr = 16'h8000; wdata = ~rom_m[0]; wen = 1'b1;
        #1;
        chk("rom_wr_err", err, 1'b1);
        cyc();
        wen = 1'b0;
        #1;
        chk("err_one_cycle", err, 1'b0);
        rd("rom_unchanged", 16'h8000, rom_m[0], 1'b0);

        // Randomized mixed traffic over RAM/SRAM/ROM/PPU
        for (int i = 0; i < 300; i++) begin
            region = int'($urandom_range(0, 3));
            op     = int'($urandom_range(0, 4));
            case (region)
                0: a = 16'($urandom_range(0, 16'h1FFF));
                1: a = 16'h6000 + 16'($urandom_range(0, 16'h1FFF));
                2: a = 16'h8000 | 16'(rom_keys[$urandom_range(0, rom_keys.size() - 1)]);
                default: a = 16'h2000 + 16'($urandom_range(0, 16'h1FFF));
            endcase
            d = 8'($urandom);
            ppu_rdata = 8'($urandom);
            addr = a; wdata = d;
            ren = (op <= 1) || (op == 4);
            wen = (op >= 2);
            #1;
            if (op <= 1) begin
                chk("rnd_rdata", rdata, (region == 3) ? ppu_rdata : exp_read(a));
                chk("rnd_rd_err", err, 1'b0);
                chk("rnd_ppu_ren", ppu_ren, region == 3);
            end else begin
                chk("rnd_wr_err", err, (region == 2) || (op == 4));
                chk("rnd_ppu_wen", ppu_wen, region == 3);
                if (op == 4) chk("rnd_both_rdata", rdata, 8'h00);
                if (region == 3) begin
                    chk("rnd_ppu_waddr", ppu_addr, a[2:0]);
                    chk("rnd_ppu_wdata", ppu_wdata, d);
                end
            end
            cyc();
            ren = 1'b0; wen = 1'b0;
            if (op >= 2) begin
                if (region == 0) ram_m[int'(a) % 2048] = d;
                if (region == 1) sram_m[int'(a) - 32'h6000] = d;
            end
        end

        // Joypads: strobe high holds bit0, then a latched serial report
        btn1 = 8'b1000_0001; btn2 = 8'($urandom);
        joy1_btn = btn1; joy2_btn = btn2;
        wr(16'h4016, 8'h01);
        cyc();
        for (int k = 0; k < 3; k++) rd("joy_strobe_hold", 16'h4016, {7'b0, btn1[0]}, 1'b0);
        wr(16'h4016, 8'h00);
        joy1_btn = 8'($urandom); joy2_btn = 8'($urandom);
        for (int k = 0; k < 10; k++)
            rd("joy1_bit", 16'h4016, (k < 8) ? 8'((btn1 >> k) & 8'h01) : 8'h01, 1'b0);
        for (int k = 0; k < 10; k++)
            rd("joy2_bit", 16'h4017, (k < 8) ? 8'((btn2 >> k) & 8'h01) : 8'h01, 1'b0);

        // Unimplemented IO space
        rd("io_rd_4000", 16'h4000, 8'h00, 1'b1);
        rd("io_rd_4014", 16'h4014, 8'h00, 1'b1);
        addr = 16'h5FFF; wen = 1'b1;
        #1;
        chk("io_wr_5fff_err", err, 1'b1);
        addr = 16'h4017;
        #1;
        chk("io_wr_4017_err", err, 1'b0);
        cyc();
        wen = 1'b0;

        // Full DMA from RAM page $02, with ignored CPU traffic mid-stall
        wr(16'h0010, 8'h33);
        for (int i = 0; i < 256; i++) wr(16'h0200 + 16'(i), 8'(i) ^ 8'h5A);
        for (int i = 0; i < 256; i++) exp_data[i] = 8'(i) ^ 8'h5A;
        run_dma(8'h02, -1, st, nw, ne, st4, nw4);
        chk("dma_stall", st, 513);
        chk("dma_writes", nw, 256);
        chk("dma_err_count", ne, 0);
        chk("dma4_stall", st4, 9);
        chk("dma4_writes", nw4, 4);
        chk("dma_rdy_back", rdy, 1'b1);
        rd("dma_cpu_wr_ignored", 16'h0010, ram_m[16'h0010], 1'b0);

        // Reset abort at stall cycle 100 from ROM page $80, then restart
        for (int i = 0; i < 256; i++) exp_data[i] = rom_m[i];
        run_dma(8'h80, 99, st, nw, ne, st4, nw4);
        chk("abort_stall", st, 100);
        chk("abort_writes", nw, 49);
        chk("abort_rdy", rdy, 1'b1);
        chk("abort_ppu_wen", ppu_wen, 1'b0);
        clear_model();
        rd("abort_ram_cleared", 16'h0005, 8'h00, 1'b0);
        run_dma(8'h80, -1, st, nw, ne, st4, nw4);
        chk("restart_stall", st, 513);
        chk("restart_writes", nw, 256);

        // DMA from the PPU range: zeros, one err per source access
        for (int i = 0; i < 256; i++) exp_data[i] = 8'h00;
        run_dma(8'h20, -1, st, nw, ne, st4, nw4);
        chk("ppu_src_stall", st, 513);
        chk("ppu_src_writes", nw, 256);
        chk("ppu_src_errs", ne, 256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
